// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 10110 sequence detector: valid/ready word in, one bit out per
// enabled cycle. Define SER_PARITY_EN to append an even-parity bit after each word.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dout_q, dout_d;

  logic             first_bit, next_bit, last_bit, accept;
  logic [WIDTH-1:0] sreg_shifted;

  // The current bit always sits at the outgoing end of sreg_q; next_bit is its neighbour.
  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit    = din[WIDTH-1];
      next_bit     = sreg_q[WIDTH-2];
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit    = din[0];
      next_bit     = sreg_q[1];
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  assign last_bit = (cnt_q == CntLast);

`ifdef SER_PARITY_EN
  logic parity_q, parity_d;

  assign din_ready = rst & ((state_q == StIdle) | ((state_q == StParity) & shift_en));
`else
  assign din_ready = rst & ((state_q == StIdle) |
                            ((state_q == StShift) & last_bit & shift_en));
`endif

  assign accept = din_valid & din_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d = StShift;
      sreg_d  = din;
      cnt_d   = '0;
      dout_d  = first_bit;
`ifdef SER_PARITY_EN
      parity_d = ^din;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StShift: begin
          if (shift_en) begin
            if (!last_bit) begin
              sreg_d = sreg_shifted;
              cnt_d  = cnt_q + CntW'(1);
              dout_d = next_bit;
            end else begin
              sreg_d = '0;
              cnt_d  = '0;
`ifdef SER_PARITY_EN
              state_d = StParity;
              dout_d  = parity_q;
`else
              state_d = StIdle;
              dout_d  = 1'b0;
`endif
            end
          end
        end
`ifdef SER_PARITY_EN
        StParity: begin
          if (shift_en) begin
            state_d = StIdle;
            dout_d  = 1'b0;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          dout_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // dout_q is cleared on every return to idle, so it is already 0 whenever dout_valid is 0.
  assign dout       = dout_q;
  assign dout_valid = (state_q != StIdle);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first 8-bit instance and an LSB-first 5-bit one.
module tb_serial_bit_feeder;

`ifdef SER_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int L = 8 + Par;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shift_en = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, dout, dout_valid, busy;
  logic [4:0] din5 = '0;
  logic       din_valid5 = 1'b0;
  logic       din_ready5, dout5, dout_valid5, busy5;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .shift_en(shift_en), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(5), .MSB_FIRST(0)) u_dut5 (
    .clk(clk), .rst(rst), .din(din5), .din_valid(din_valid5), .din_ready(din_ready5),
    .shift_en(shift_en), .dout(dout5), .dout_valid(dout_valid5), .busy(busy5)
  );

  task automatic test_reset();
    #3;
    din_valid = 1'b1;
    #1;
    chk_cnt++;
    if ({dout, dout_valid, busy, din_ready} !== 4'b0000)
      $display("FAIL reset_outs: got %b want 0000", {dout, dout_valid, busy, din_ready});
    else pass_cnt++;
    chk_cnt++;
    if ({dout5, dout_valid5, busy5, din_ready5} !== 4'b0000)
      $display("FAIL reset_outs5: got %b want 0000", {dout5, dout_valid5, busy5, din_ready5});
    else pass_cnt++;
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({din_ready, busy} !== 2'b10)
      $display("FAIL reset_release: ready,busy got %b want 10", {din_ready, busy});
    else pass_cnt++;
  endtask

  // Single word, shift_en held high; expected bits given MSB first plus parity.
  task automatic run_word(input logic [7:0] w, input logic [8:0] exp_bits, input string nm);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    shift_en = 1'b1;
    #1;
    chk_cnt++;
    if (din_ready !== 1'b1) $display("FAIL %s_ready0: got %b want 1", nm, din_ready);
    else pass_cnt++;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      #1;
      chk_cnt++;
      if ({dout, dout_valid, busy} !== {exp_bits[8-i], 2'b11})
        $display("FAIL %s_bit%0d: dout,valid,busy got %b want %b", nm, i,
                 {dout, dout_valid, busy}, {exp_bits[8-i], 2'b11});
      else pass_cnt++;
      if (i > 0 && i < L - 1) begin
        chk_cnt++;
        if (din_ready !== 1'b0) $display("FAIL %s_ready%0d: got 1 want 0", nm, i);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    #1;
    chk_cnt++;
    if ({dout, dout_valid, busy, din_ready} !== 4'b0001)
      $display("FAIL %s_idle: dout,valid,busy,ready got %b want 0001", nm,
               {dout, dout_valid, busy, din_ready});
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    // 8'hB0 = 1011_0000, three ones -> parity 1
    run_word(8'hB0, 9'b1011_0000_1, "single");
  endtask

  task automatic test_back_to_back();
    logic [2*L-1:0] stream;
`ifdef SER_PARITY_EN
    stream = {8'b1011_0000, 1'b1, 8'b0010_1100, 1'b1};
`else
    stream = {8'b1011_0000, 8'b0010_1100};
`endif
    @(negedge clk);
    din = 8'hB0;
    din_valid = 1'b1;
    shift_en = 1'b1;
    for (int c = 0; c <= 2 * L; c++) begin
      if (c == 1) din = 8'h2C;  // not yet accepted: must not disturb the word in flight
      if (c == L + 1) din_valid = 1'b0;
      #1;
      if (c < 2 * L) begin
        chk_cnt++;
        if (din_ready !== (c == 0 || c == L))
          $display("FAIL b2b_ready_c%0d: got %b want %b", c, din_ready, (c == 0 || c == L));
        else pass_cnt++;
      end
      if (c >= 1) begin
        chk_cnt++;
        if ({dout, dout_valid} !== {stream[2*L-c], 1'b1})
          $display("FAIL b2b_bit_c%0d: dout,valid got %b want %b", c, {dout, dout_valid},
                   {stream[2*L-c], 1'b1});
        else pass_cnt++;
      end
      @(negedge clk);
    end
    #1;
    chk_cnt++;
    if ({dout, dout_valid, busy} !== 3'b000)
      $display("FAIL b2b_idle: dout,valid,busy got %b want 000", {dout, dout_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [8:0] bits;
    int idx;
    int en_valid;
    bits = 9'b1011_0000_1;
    idx = 0;
    en_valid = 0;
    @(negedge clk);
    din = 8'hB0;
    din_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int c = 1; c <= 11 + Par; c++) begin
      shift_en = !(c >= 3 && c <= 5);
      #1;
      chk_cnt++;
      if ({dout, dout_valid} !== {bits[8-idx], 1'b1})
        $display("FAIL stall_c%0d: dout,valid got %b want %b", c, {dout, dout_valid},
                 {bits[8-idx], 1'b1});
      else pass_cnt++;
      if (dout_valid && shift_en) en_valid++;
      if (shift_en) idx++;
      @(negedge clk);
    end
    shift_en = 1'b1;
    #1;
    chk_cnt++;
    if ({dout_valid, busy, din_ready} !== 3'b001)
      $display("FAIL stall_idle: valid,busy,ready got %b want 001", {dout_valid, busy, din_ready});
    else pass_cnt++;
    chk_cnt++;
    if (en_valid !== L) $display("FAIL stall_count: got %0d want %0d", en_valid, L);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    din = 8'hFF;
    din_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_cnt++;
    if ({dout, dout_valid, busy} !== 3'b111)
      $display("FAIL midrst_pre: dout,valid,busy got %b want 111", {dout, dout_valid, busy});
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({dout, dout_valid, busy, din_ready} !== 4'b0000)
      $display("FAIL midrst_async: dout,valid,busy,ready got %b want 0000",
               {dout, dout_valid, busy, din_ready});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({dout_valid, busy, din_ready} !== 3'b001)
      $display("FAIL midrst_release: valid,busy,ready got %b want 001",
               {dout_valid, busy, din_ready});
    else pass_cnt++;
    run_word(8'hB0, 9'b1011_0000_1, "postrst");
  endtask

  task automatic test_lsb_first();
    // 5'b01101 sent LSB first -> 1,0,1,1,0 then parity 1
    logic [5:0] exp_bits;
    exp_bits = 6'b10110_1;
    @(negedge clk);
    din5 = 5'b01101;
    din_valid5 = 1'b1;
    shift_en = 1'b1;
    #1;
    chk_cnt++;
    if (din_ready5 !== 1'b1) $display("FAIL lsb_ready0: got %b want 1", din_ready5);
    else pass_cnt++;
    @(negedge clk);
    din_valid5 = 1'b0;
    for (int i = 0; i < 5 + Par; i++) begin
      #1;
      chk_cnt++;
      if ({dout5, dout_valid5} !== {exp_bits[5-i], 1'b1})
        $display("FAIL lsb_bit%0d: dout,valid got %b want %b", i, {dout5, dout_valid5},
                 {exp_bits[5-i], 1'b1});
      else pass_cnt++;
      @(negedge clk);
    end
    #1;
    chk_cnt++;
    if ({dout5, dout_valid5, busy5, din_ready5} !== 4'b0001)
      $display("FAIL lsb_idle: dout,valid,busy,ready got %b want 0001",
               {dout5, dout_valid5, busy5, din_ready5});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_lsb_first();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
